// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode type and the opcodes
// that the arbiter and its neighbours refer to by name.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    // Undefined code: the ALU drives zero for it, so it doubles as an idle op.
    localparam alu_op_t ALU_NOP = 4'b1111;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a rotating priority pointer,
// issued only while the downstream slot can accept.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   search_sum;
    logic [IW-1:0] search_idx;

    // Scan from ptr upward with wraparound; first valid requester wins.
    always_comb begin
        gnt        = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        ptr_d      = ptr_q;
        search_sum = '0;
        search_idx = '0;
        if (en && !rst) begin
            for (int i = 0; i < N; i++) begin
                search_sum = {1'b0, ptr_q} + (IW + 1)'(i);
                if (search_sum >= (IW + 1)'(N)) begin
                    search_sum = search_sum - (IW + 1)'(N);
                end
                search_idx = search_sum[IW-1:0];
                if (!gnt_valid && req[search_idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = search_idx;
                end
            end
            if (gnt_valid) begin
                gnt[gnt_idx] = 1'b1;
                ptr_d        = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: round-robin
// grant, operand mux into the ALU, and a single registered response slot.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]     req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0]     req_b,
    input  logic [N_REQ-1:0][3:0]           req_sel,
    output logic [WIDTH-1:0]                alu_a,
    output logic [WIDTH-1:0]                alu_b,
    output logic [3:0]                      alu_sel,
    input  logic [WIDTH-1:0]                alu_out,
    input  logic                            alu_cout,
    input  logic                            alu_z,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(N_REQ)-1:0]        rsp_id,
    output logic [WIDTH-1:0]                rsp_data,
    output logic                            rsp_cout,
    output logic                            rsp_z
);

    localparam int IW = $clog2(N_REQ);

    logic          slot_free;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

    logic             rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]    rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_cout_q,  rsp_cout_d;
    logic             rsp_z_q,     rsp_z_d;

    // A drain at this edge frees the slot, so a new grant can land without a bubble.
    assign slot_free = !rsp_valid_q || rsp_ready;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (slot_free),
        .gnt       (req_ready),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = ALU_NOP;
        if (gnt_valid) begin
            alu_a   = req_a[gnt_idx];
            alu_b   = req_b[gnt_idx];
            alu_sel = req_sel[gnt_idx];
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_z_d     = rsp_z_q;
        if (gnt_valid) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_data_d  = alu_out;
            rsp_cout_d  = alu_cout;
            rsp_z_d     = alu_z;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_z_q     <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_z_q     <= rsp_z_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_z     = rsp_z_q;

endmodule
